// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one L1 requester at a time, broadcasts the snoop, collects sharer data or goes to L2.
// Latency grant->req_done: 3 cycles when a snooper supplies the line, 3 + L2 wait otherwise (writebacks skip snooping).
// Backpressure: requests are held until req_done; the L2 channel stalls in MEM until mem_ready. Optional: ARB_ROUND_ROBIN_EN.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

package snoop_bus_pkg;
  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;
endpackage

module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic     [NUM_CORES-1:0]                       req_valid,
  input  logic     [NUM_CORES*(`ADDR_BITS-`OFFSET_BITS)-1:0] req_addr,
  input  bus_req_t [NUM_CORES-1:0]                       req_type,
  input  logic     [NUM_CORES*`CACHELINE_BITS-1:0]       req_wdata,
  output logic     [NUM_CORES-1:0]                       req_done,
  output logic     [`CACHELINE_BITS-1:0]                 resp_data,
  output logic                                           resp_shared,
  output logic     [NUM_CORES-1:0]                       snoop_valid,
  output logic     [`ADDR_BITS-`OFFSET_BITS-1:0]         snoop_addr,
  output bus_req_t                                       snoop_req,
  input  logic     [NUM_CORES-1:0]                       snoop_shared,
  input  logic     [NUM_CORES*`CACHELINE_BITS-1:0]       snoop_data,
  output logic                                           mem_valid,
  output logic                                           mem_we,
  output logic     [`ADDR_BITS-`OFFSET_BITS-1:0]         mem_addr,
  output logic     [`CACHELINE_BITS-1:0]                 mem_wdata,
  input  logic                                           mem_ready,
  input  logic     [`CACHELINE_BITS-1:0]                 mem_rdata
);

  localparam int LA = `ADDR_BITS - `OFFSET_BITS;
  localparam int CL = `CACHELINE_BITS;
  localparam int IW = $clog2(NUM_CORES);

  typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, MEM, DONE} state_t;

  state_t state, state_nxt;

  // Per-core views of the flattened buses
  logic [NUM_CORES-1:0][LA-1:0] addr_arr;
  logic [NUM_CORES-1:0][CL-1:0] wdata_arr;
  logic [NUM_CORES-1:0][CL-1:0] sdata_arr;
  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;
  assign sdata_arr = snoop_data;

  logic [IW-1:0]        pick_idx, win_idx, shr_idx;
  logic                 pick_any, shr_any;
  logic [NUM_CORES-1:0] win_mask, shr_vec;
  bus_req_t             lat_type;
  logic [LA-1:0]        lat_addr;
  logic [CL-1:0]        lat_wdata;

  assign win_mask   = NUM_CORES'(1) << win_idx;
  assign snoop_addr = lat_addr;
  assign snoop_req  = lat_type;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]            ptr;
  logic [2*NUM_CORES-1:0]   rr_dbl;
  logic [IW:0]              rr_sum;

  // Round-robin pick: first pending request at or after the pointer
  always_comb begin
    rr_dbl   = {req_valid, req_valid} >> ptr;
    pick_any = 1'b0;
    pick_idx = '0;
    rr_sum   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rr_dbl[k]) begin
        pick_any = 1'b1;
        rr_sum   = {1'b0, ptr} + (IW+1)'(k);
        pick_idx = (rr_sum >= (IW+1)'(NUM_CORES)) ? IW'(rr_sum - (IW+1)'(NUM_CORES)) : IW'(rr_sum);
      end
    end
  end

  // Pointer moves just past the winner at grant time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (state == IDLE && pick_any) begin
      ptr <= (pick_idx == IW'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  // Fixed priority pick: lowest pending index wins
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        pick_any = 1'b1;
        pick_idx = IW'(k);
      end
    end
  end
`endif

  // Lowest-index sharer among non-winner snoopers
  always_comb begin
    shr_vec = snoop_shared & ~win_mask;
    shr_any = |shr_vec;
    shr_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (shr_vec[k]) shr_idx = IW'(k);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nxt   = state;
    req_done    = '0;
    snoop_valid = '0;
    mem_valid   = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = (req_type[pick_idx] == BUS_WB) ? MEM : SNOOP;
      end
      SNOOP: begin
        snoop_valid = ~win_mask;
        state_nxt   = COLLECT;
      end
      COLLECT: begin
        if (lat_type == BUS_UPGR || shr_any) state_nxt = DONE;
        else                                 state_nxt = MEM;
      end
      MEM: begin
        mem_valid = 1'b1;
        mem_we    = (lat_type == BUS_WB);
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        req_done  = win_mask;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch and response capture; responses hold between transactions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_idx     <= '0;
      lat_addr    <= '0;
      lat_type    <= BUS_RD;
      lat_wdata   <= '0;
      resp_data   <= '0;
      resp_shared <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win_idx   <= pick_idx;
            lat_addr  <= addr_arr[pick_idx];
            lat_type  <= req_type[pick_idx];
            lat_wdata <= wdata_arr[pick_idx];
          end
        end
        COLLECT: begin
          if (lat_type != BUS_UPGR && shr_any) begin
            resp_data   <= sdata_arr[shr_idx];
            resp_shared <= 1'b1;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (lat_type != BUS_WB) resp_data <= mem_rdata;
            resp_shared <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
